// File: rtl/spwm_pkg.sv
// spwm_pkg
//   Shared definitions for the SPWM carrier controller: FSM state
//   encoding and the divider value loaded at reset.
package spwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } carrier_state_t;

  localparam int DEFAULT_DIV = 32;

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler
//   Divides clk down to a one-cycle step pulse every div cycles while run
//   is high. The count is held at 0 while run is low, so the first step
//   lands div cycles after run rises. A div of 0 behaves as 1.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   run   - count enable (level)
//   div   - clk cycles per step
//   step  - one-cycle pulse on the last count of each step interval
module step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] last;

  // div = 0 and div = 1 share a terminal count of 0 (step every cycle)
  assign last = (div == '0) ? '0 : div - DIV_W'(1);
  assign step = run && (count == last);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (step) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spwm_carrier_ctrl.sv
// spwm_carrier_ctrl
//   Sequencer for a bank of triangular carrier generators. Holds them in
//   reset until enabled, issues a common step pulse, tracks the carrier
//   with a mirror counter to flag peak/valley, and only swaps the step
//   divider on a valley so each carrier period runs at a single rate.
//   Stopping waits for the next valley so the carrier ends at zero.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   enable        - run request (level)
//   div_in        - new clk-cycles-per-step divider
//   div_load      - one-cycle strobe capturing div_in
//   carrier_rst   - reset to the triangular generators
//   step          - one-cycle step pulse to the generators
//   peak / valley - one-cycle turn-around flags, coincident with step
//   running       - high in RUN and STOP
//   div_pending   - a loaded divider is waiting for a valley
module spwm_carrier_ctrl #(
  parameter int MAX_A       = 128,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = spwm_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             carrier_rst,
  output logic             step,
  output logic             peak,
  output logic             valley,
  output logic             running,
  output logic             div_pending
);
  import spwm_pkg::*;

  localparam int MW = (MAX_A > 1) ? $clog2(MAX_A) : 1;

  carrier_state_t   state;
  logic [DIV_W-1:0] div_active;
  logic [DIV_W-1:0] div_pend;
  logic [MW-1:0]    mirror;
  logic             dir_up;

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (running),
    .div   (div_active),
    .step  (step)
  );

  // Turn-around happens on the step that would leave 0..MAX_A-1
  assign peak   = step &&  dir_up && (mirror == MW'(MAX_A - 1));
  assign valley = step && !dir_up && (mirror == '0);

  // carrier_rst and running are registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      carrier_rst <= 1'b1;
      running     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= ARM;
        end
        ARM: begin
          state       <= RUN;
          carrier_rst <= 1'b0;
          running     <= 1'b1;
        end
        RUN: begin
          if (!enable) state <= STOP;
        end
        STOP: begin
          if (valley) begin
            state       <= IDLE;
            carrier_rst <= 1'b1;
            running     <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          carrier_rst <= 1'b1;
          running     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !running) begin
      mirror <= '0;
      dir_up <= 1'b1;
    end else if (step) begin
      if (dir_up) begin
        if (mirror == MW'(MAX_A - 1)) dir_up <= 1'b0;
        else                          mirror <= mirror + MW'(1);
      end else begin
        if (mirror == '0) dir_up <= 1'b1;
        else              mirror <= mirror - MW'(1);
      end
    end
  end

  // While stopped a load takes effect at once; while running it waits for
  // a valley. A load landing on a valley is queued for the following one.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_active  <= DIV_W'(DEFAULT_DIV);
      div_pend    <= '0;
      div_pending <= 1'b0;
    end else if (!running) begin
      if (div_load) begin
        div_active  <= div_in;
        div_pending <= 1'b0;
      end else if (div_pending) begin
        div_active  <= div_pend;
        div_pending <= 1'b0;
      end
    end else begin
      if (valley && div_pending) begin
        div_active  <= div_pend;
        div_pending <= 1'b0;
      end
      if (div_load) begin
        div_pend    <= div_in;
        div_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spwm_carrier_ctrl.md
SPWM_CARRIER_CTRL -- requirements
Module: spwm_carrier_ctrl

Interface
REQ-001 Parameter MAX_A, default 128, SHALL be the carrier amplitude bound, matched to the driven triangular generators.
REQ-002 Parameter DIV_W, default 16, SHALL be the width of the step divider.
REQ-003 Parameter DEFAULT_DIV, default 32, SHALL be the divider value in use after reset.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-006 Port enable, input, 1 bit, SHALL be the run request (level).
REQ-007 Port div_in, input, DIV_W bits, SHALL be the new clk-cycles-per-step divider.
REQ-008 Port div_load, input, 1 bit, SHALL be a one-cycle strobe that captures div_in.
REQ-009 Port carrier_rst, output, 1 bit, SHALL drive the reset of all triangular generators.
REQ-010 Port step, output, 1 bit, SHALL be a one-cycle step pulse to all generators.
REQ-011 Port peak, output, 1 bit, SHALL pulse one cycle when the carrier turns from up to down.
REQ-012 Port valley, output, 1 bit, SHALL pulse one cycle when the carrier turns from down to up.
REQ-013 Port running, output, 1 bit, SHALL be high in RUN and STOP.
REQ-014 Port div_pending, output, 1 bit, SHALL be high while a loaded divider awaits application.

Function
REQ-015 The FSM SHALL have the states IDLE, ARM, RUN and STOP.
REQ-016 Transitions SHALL be: IDLE->ARM on enable=1; ARM->RUN unconditionally after 1 cycle; RUN->STOP on enable=0; STOP->IDLE in the cycle after a valley pulse.
REQ-017 enable toggling during STOP SHALL be ignored; re-arming occurs only from IDLE.
REQ-018 carrier_rst SHALL be 1 in IDLE and ARM and 0 in RUN and STOP.
REQ-019 In RUN and STOP, a prescaler SHALL count 0..div_active-1 and assert step in the cycle where count = div_active-1, then wrap to 0.
REQ-020 The prescaler SHALL be held at 0 in IDLE and ARM; the first step SHALL occur div_active cycles after entering RUN.
REQ-021 A divider value of 0 SHALL be treated as 1, so step is asserted every cycle.
REQ-022 A mirror counter (0..MAX_A-1) and direction flag SHALL track the generators, starting from 0/up on ARM.
REQ-023 On each step while up: if mirror+1 < MAX_A, increment; else set direction to down without changing the value, and pulse peak in the same cycle as that step.
REQ-024 On each step while down: if mirror > 0, decrement; else set direction to up, and pulse valley in the same cycle as that step.
REQ-025 One carrier period SHALL therefore be 2*MAX_A steps, which is 2*MAX_A*div_active clk cycles.
REQ-026 A div_load strobe SHALL latch div_in into a pending register and set div_pending.
REQ-027 A later div_load before application SHALL overwrite the pending value.
REQ-028 In RUN or STOP, the pending value SHALL be copied to div_active on the valley cycle and div_pending SHALL clear.
REQ-029 The new divider SHALL govern the prescaler from the next count onward.
REQ-030 In IDLE or ARM, a div_load SHALL apply to div_active on the next cycle without waiting for a valley.
REQ-031 A div_load coincident with a valley SHALL be applied at the next valley, not the current one.
REQ-032 peak and valley SHALL never be asserted in the same cycle.
REQ-033 peak and valley SHALL only be asserted coincident with step.

Reset
REQ-034 On reset=1 the block SHALL enter IDLE, with prescaler 0, mirror 0, direction up, div_active = DEFAULT_DIV, pending cleared and div_pending 0.
REQ-035 Outputs during and after reset SHALL be carrier_rst=1 and step=peak=valley=running=0.
REQ-036 Reset asserted mid-RUN or mid-STOP SHALL abort immediately; no valley wait is performed.
REQ-037 reset SHALL take priority over div_load and enable.

Structure
REQ-038 The FSM state encodings and DEFAULT_DIV SHALL live in the shared package spwm_pkg.
REQ-039 The prescaler SHALL be a sub-module step_prescaler, with inputs clk, reset, run and div, and output step.

Verification (bench with MAX_A=8)
REQ-040 Scenario: div=3, enable=1 from reset -> carrier_rst low 2 cycles after enable; first step 3 cycles later; peak on the 8th step; valley on the 16th step; 48 cycles per period.
REQ-041 Scenario: div_load of 5 mid-period while div=3 -> div_pending=1 until valley; step spacing changes from 3 to 5 after that valley.
REQ-042 Scenario: two div_loads (4, then 6) before the valley -> only 6 is applied.
REQ-043 Scenario: enable dropped at mirror=3 going up -> running stays 1 until valley, then IDLE with carrier_rst=1.
REQ-044 Scenario: reset asserted mid-RUN -> next cycle IDLE, step=0, carrier_rst=1, div_active=DEFAULT_DIV.
REQ-045 Scenario: div_in=0 -> step asserted every cycle, period 16 cycles.
